// File: rtl/decoder3x8_pipe.sv
// decoder3x8_pipe: 3-to-8 one-hot decoder with a 2-entry output buffer and, under `DEC_HITCOUNT_EN, a per-line hit counter bank.
// Latency: a word accepted into an empty buffer is presented with out_valid=1 right after its accepting edge.
// Backpressure: in_ready drops when both entries are occupied and depends only on registered occupancy, never on out_ready.

module decoder3x8_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  input  logic         pop_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  assign push_rdy = (cnt != CW'(DEPTH));
  assign pop_vld  = (cnt != '0);
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      // simultaneous push and pop leaves occupancy unchanged
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module decoder3x8_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  input  logic             in_en,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_onehot,
  input  logic             out_ready,
  input  logic [2:0]       hit_sel,
  input  logic             hit_clr,
  output logic [CNT_W-1:0] hit_count
);
  logic [7:0] word;

  assign word = in_en ? (8'b1 << in_code) : 8'h00;

  decoder3x8_fifo #(.W(8), .DEPTH(2)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid),
    .push_dat (word),
    .push_rdy (in_ready),
    .pop_vld  (out_valid),
    .pop_dat  (out_onehot),
    .pop_rdy  (out_ready)
  );

`ifdef DEC_HITCOUNT_EN
  logic             accept;
  logic [CNT_W-1:0] hits [8];

  assign accept = in_valid && in_ready;

  // clear takes priority over a same-cycle increment; counters saturate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) hits[i] <= '0;
    end else if (hit_clr) begin
      for (int i = 0; i < 8; i++) hits[i] <= '0;
    end else if (accept && in_en && (hits[in_code] != '1)) begin
      hits[in_code] <= hits[in_code] + 1'b1;
    end
  end

  assign hit_count = hits[hit_sel];
`else
  logic unused_hit;

  assign unused_hit = ^{hit_sel, hit_clr};
  assign hit_count  = '0;
`endif

endmodule

// File: tb/tb_decoder3x8_pipe.sv
// Directed bench for decoder3x8_pipe: stream, back-pressure, disabled decode, async reset and hit counters (CNT_W=2).
module tb_decoder3x8_pipe;
`ifdef DEC_HITCOUNT_EN
  localparam bit HC_EN = 1'b1;
`else
  localparam bit HC_EN = 1'b0;
`endif
  localparam int HMAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_en;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_onehot;
  logic       out_ready;
  logic [2:0] hit_sel;
  logic       hit_clr;
  logic [1:0] hit_count;

  int tests = 0;
  int fails = 0;
  int exp_hits [8];

  decoder3x8_pipe #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_en      (in_en),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .out_ready  (out_ready),
    .hit_sel    (hit_sel),
    .hit_clr    (hit_clr),
    .hit_count  (hit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void model_hit(input int c);
    if (HC_EN && exp_hits[c] < HMAX) exp_hits[c]++;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_en = 1'b0;
    out_ready = 1'b0; hit_sel = 3'd0; hit_clr = 1'b0;
    for (int i = 0; i < 8; i++) exp_hits[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_onehot !== 8'h00) begin fails++; $display("FAIL reset_out_onehot got %h want 00", out_onehot); end
    tests++; if (hit_count !== 2'd0) begin fails++; $display("FAIL reset_hit_count got %0d want 0", hit_count); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_idle got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [7:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_code = i[2:0]; in_en = 1'b1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready code %0d got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      model_hit(i);
      exp = 8'h01 << i;
      tests++; if (out_valid !== 1'b1 || out_onehot !== exp)
        begin fails++; $display("FAIL stream_word code %0d got v=%b %h want v=1 %h", i, out_valid, out_onehot, exp); end
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd3; in_en = 1'b1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept3 got %b want 1", in_ready); end
    @(posedge clk); #1; model_hit(3);
    @(negedge clk); in_code = 3'd5;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept5 got %b want 1", in_ready); end
    @(posedge clk); #1; model_hit(5);
    @(negedge clk); in_code = 3'd6;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    tests++; if (out_onehot !== 8'h08) begin fails++; $display("FAIL bp_hold_a got %h want 08", out_onehot); end
    @(posedge clk); #1;
    tests++; if (out_onehot !== 8'h08 || out_valid !== 1'b1)
      begin fails++; $display("FAIL bp_hold_b got v=%b %h want v=1 08", out_valid, out_onehot); end
    @(negedge clk); out_ready = 1'b1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_still_full got %b want 0", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_onehot !== 8'h20) begin fails++; $display("FAIL bp_second got %h want 20", out_onehot); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
    @(posedge clk); #1; model_hit(6);
    tests++; if (out_onehot !== 8'h40 || out_valid !== 1'b1)
      begin fails++; $display("FAIL bp_third got v=%b %h want v=1 40", out_valid, out_onehot); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_disabled();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_code = 3'd2; in_en = 1'b0; hit_sel = 3'd2;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_onehot !== 8'h00)
      begin fails++; $display("FAIL dis_word got v=%b %h want v=1 00", out_valid, out_onehot); end
    tests++; if (hit_count !== 2'(exp_hits[2]))
      begin fails++; $display("FAIL dis_counter2 got %0d want %0d", hit_count, exp_hits[2]); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd1; in_en = 1'b1;
    @(posedge clk); #1; model_hit(1);
    @(negedge clk); in_code = 3'd4;
    @(posedge clk); #1; model_hit(4);
    @(negedge clk); in_valid = 1'b0; hit_sel = 3'd1;
    tests++; if (in_ready !== 1'b0 || out_onehot !== 8'h02)
      begin fails++; $display("FAIL mid_full got r=%b %h want r=0 02", in_ready, out_onehot); end
    tests++; if (hit_count !== 2'(exp_hits[1]))
      begin fails++; $display("FAIL mid_count1 got %0d want %0d", hit_count, exp_hits[1]); end
    #2; rst = 1'b1; #1;
    for (int i = 0; i < 8; i++) exp_hits[i] = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready got %b want 1", in_ready); end
    tests++; if (out_onehot !== 8'h00) begin fails++; $display("FAIL mid_rst_word got %h want 00", out_onehot); end
    tests++; if (hit_count !== 2'd0) begin fails++; $display("FAIL mid_rst_count got %0d want 0", hit_count); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_hit_saturate();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_code = 3'd7; in_en = 1'b1; hit_sel = 3'd7;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1; model_hit(7);
      tests++; if (out_onehot !== 8'h80 || out_valid !== 1'b1)
        begin fails++; $display("FAIL sat_word #%0d got v=%b %h want v=1 80", k, out_valid, out_onehot); end
      tests++; if (hit_count !== 2'(exp_hits[7]))
        begin fails++; $display("FAIL sat_count #%0d got %0d want %0d", k, hit_count, exp_hits[7]); end
    end
    @(negedge clk); hit_clr = 1'b1;
    @(posedge clk); #1; exp_hits[7] = 0;
    tests++; if (hit_count !== 2'd0) begin fails++; $display("FAIL clr_wins got %0d want 0", hit_count); end
    tests++; if (out_onehot !== 8'h80) begin fails++; $display("FAIL clr_word got %h want 80", out_onehot); end
    @(negedge clk); hit_clr = 1'b0;
    @(posedge clk); #1; model_hit(7);
    tests++; if (hit_count !== 2'(exp_hits[7]))
      begin fails++; $display("FAIL post_clr_count got %0d want %0d", hit_count, exp_hits[7]); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_drain got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_disabled();
    test_reset_midstream();
    test_hit_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decoder3x8_pipe.md
# decoder3x8_pipe

Registered 3-to-8 one-hot decoder with a valid/ready stream interface and a 2-entry output buffer. It is the companion of the 8x3 encoder: it turns a 3-bit code stream back into one-hot select lines for downstream consumers that may stall. An optional per-line hit counter bank records decoded traffic for debug.

## Interface
- `CNT_W`, default 8: width of each hit counter (used only with `DEC_HITCOUNT_EN`).

Ports (clock and reset first):
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: code present on `in_code`.
- `in_code` input 3: binary code, 0..7.
- `in_en` input 1: decode enable, sampled with the code. When 0, the output word is 8'h00.
- `in_ready` output 1: buffer can accept a word.
- `out_valid` output 1: `out_onehot` holds a valid word.
- `out_onehot` output 8: decoded word; bit `in_code` is set when enabled.
- `out_ready` input 1: consumer accepts the word.
- `hit_sel` input 3: selects the counter shown on `hit_count`.
- `hit_clr` input 1: synchronous clear of all hit counters.
- `hit_count` output CNT_W: value of counter `hit_sel`.

## Operation
- Accept (push) occurs on a cycle with `in_valid && in_ready`. The word written is `8'b1 << in_code` if `in_en=1`, else 8'h00.
- Buffer:
  - 2-entry FIFO with occupancy `cnt` in {0,1,2}.
  - `in_ready = (cnt != 2)`, driven from the register only. There is no combinational path from `out_ready`.
  - `out_valid = (cnt != 0)`. `out_onehot` is the head entry; it is 8'h00 when empty.
- Pop occurs on a cycle with `out_valid && out_ready`.
- Occupancy update:
  - Push and pop in the same cycle: `cnt` unchanged, order preserved.
  - Push only: `cnt+1`.
  - Pop only: `cnt-1`.
  - When `cnt=2`, no push is possible because `in_ready=0`.
- Words leave in acceptance order. There is no drop and no duplication.
- `in_code` and `in_en` are ignored when `in_valid=0` or `in_ready=0`.
- Reset values: `cnt=0`, `in_ready=1`, `out_valid=0`, `out_onehot=8'h00`, all counters 0, `hit_count=0`.
- Reset asserted mid-stream discards all buffered words immediately (asynchronous reset).

## Timing
- Latency: a word accepted at edge N appears with `out_valid=1` after edge N, when the buffer was empty. If the buffer was non-empty, it appears after the earlier entries have been popped.
- Throughput: one word per cycle with `out_ready` held high. Occupancy stays at 1 in that case.
- Back-pressure:
  - With `out_ready=0`, the third consecutive offered word sees `in_ready=0`.
  - `in_ready` returns to 1 on the edge following the first pop.
- `out_onehot` is stable while `out_valid=1 && out_ready=0`.
- Hit counters:
  - Update on the edge of an accept with `in_en=1`.
  - Counter `in_code` increments by 1 and saturates at `2^CNT_W-1`; it does not wrap.
  - Accepts with `in_en=0` leave all counters unchanged.
  - `hit_clr` clears all counters on the next edge. If `hit_clr` and an accept occur in the same cycle, the clear wins and the counter ends at 0.
  - `hit_count` is combinational from `hit_sel`.

## Configuration
- `DEC_HITCOUNT_EN`:
  - Defined: the counter bank of 8 × `CNT_W` bits is built and behaves as described under Operation and Timing.
  - Undefined: no counter registers are built, `hit_count` is tied to 0, and `hit_sel`/`hit_clr` are ignored.
- Decode and buffer behaviour are identical in both builds.

## Test plan
- Reset, then stream codes 0..7 with `in_en=1` and `out_ready=1`. Required: `out_onehot` sequence 01, 02, 04, 08, 10, 20, 40, 80, each one cycle after acceptance, with `in_ready` constantly 1.
- `out_ready=0`, offer codes 3, 5, 6 on consecutive cycles. Required: 3 and 5 are accepted, `in_ready=0` on the third cycle, and `out_onehot=08` is held. Then raise `out_ready`. Required: 08, 20, 40 in that order, with code 6 accepted once `in_ready` returns to 1.
- Code 2 with `in_en=0`. Required: an output word of 8'h00 with `out_valid=1`, and counter 2 unchanged.
- Assert `rst` while `cnt=2`. Required: `out_valid=0`, `in_ready=1`, `out_onehot=00` immediately, without waiting for a clock edge.
- With `DEC_HITCOUNT_EN` and `CNT_W=2`, accept code 7 five times. Required: `hit_count=3` (saturated) at `hit_sel=7`. Then `hit_clr` in the same cycle as another code-7 accept. Required: `hit_count=0`.
- Without `DEC_HITCOUNT_EN`, repeat the previous scenario. Required: `hit_count=0` throughout, and the output stream is unchanged.
